// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the program-counter / branch-resolution stage:
// FSM encoding, default widths and the reset pc.
package pc_branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 5;
  localparam int RESET_PC   = 0;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: synchronous write, synchronous clear on reset,
// combinational read so the target feeds the next-pc mux in the same cycle.
module branch_lut #(
  parameter int LUT_AW = 5,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC and branch-resolution stage: IDLE/RUN/DONE program handshake, prioritised
// next-pc selection through the target LUT, and a saturating run-cycle counter.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_on_zero,
  input  logic              branch_flag,
  input  logic              jump_en,
  input  logic [LUT_AW-1:0] target_idx,
  input  logic              halt,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic              taken,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [1:0]        fsm_state
);

  state_t          state;
  logic [PC_W-1:0] target_pc;
  logic            redirect;

  // Table is only writable while idle, so a write never races a RUN-time read.
  branch_lut #(
    .LUT_AW (LUT_AW),
    .PC_W   (PC_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we && (state == ST_IDLE)),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (target_idx),
    .rdata (target_pc)
  );

  assign redirect  = jump_en || (branch_en && (branch_flag == branch_on_zero));
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= PC_W'(RESET_PC);
      running     <= 1'b0;
      done        <= 1'b0;
      taken       <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_RUN;
            pc          <= PC_W'(RESET_PC);
            running     <= 1'b1;
            done        <= 1'b0;
            taken       <= 1'b0;
            cycle_count <= '0;
          end
        end
        ST_RUN: begin
          // Counts every RUN cycle, stalled or not, and sticks at all-ones.
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          if (stall) begin
            taken <= 1'b0;
          end else if (halt) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            taken   <= 1'b0;
          end else if (redirect) begin
            pc    <= target_pc;
            taken <= 1'b1;
          end else begin
            pc    <= pc + PC_W'(1);
            taken <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
          taken   <= 1'b0;
        end
      endcase
    end
  end

endmodule
